// File: rtl/reset_gen_pkg.sv
// Shared definitions for the reset generator.
//   reg_addr_e : MMIO word addresses of the four registers
//   state_e    : reset sequencer states
//   CAUSE_*    : bit positions inside the CAUSE register
//   bswap32    : converts between bus byte order and register (data) order
package reset_gen_pkg;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_LIMIT = 2'd1,
    REG_KICK  = 2'd2,
    REG_CAUSE = 2'd3
  } reg_addr_e;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_W   = 3;

  // The swap is its own inverse, so it serves both the write and read paths.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/reset_gen_debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a debounce counter.
//   clk   : system clock
//   rst   : async active-high reset
//   raw   : raw asynchronous, bouncy button level
//   level : debounced level, synchronous to clk
// The debounced level only changes after the synchronised input has
// disagreed with it for 2**DEBOUNCE_BITS consecutive cycles.
module reset_gen_debounce #(
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic                     sync1;
  logic                     sync2;
  logic [DEBOUNCE_BITS-1:0] cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours (sync2 gets the
  // old sync1, not the one just loaded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/reset_gen.sv
// Global reset generator.
//   clk       : system clock
//   rst       : async active-high power-on / PLL-unlock reset
//   btn_rst   : raw active-high reset pushbutton
//   a         : MMIO word address (CTRL, LIMIT, KICK, CAUSE)
//   d         : MMIO write data, bus byte order
//   we        : MMIO write strobe, one cycle per write
//   spo       : MMIO read data, bus byte order, combinational from a
//   rst_globl : global reset, asserted asynchronously, released synchronously
// A HOLD/RUN sequencer keeps rst_globl high for HOLD_CYCLES cycles after
// power-on, a debounced button press or a watchdog expiry. CAUSE records
// which sources fired since it was last cleared.
module reset_gen
  import reset_gen_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int DEBOUNCE_BITS = 20,
  parameter int WDT_BITS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_rst,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        rst_globl
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  wdt_en_q;
  logic [WDT_BITS-1:0]   wdt_cnt_q;
  logic [WDT_BITS-1:0]   limit_q;
  logic [CAUSE_W-1:0]    cause_q, cause_d;
  logic                  btn_lvl, btn_lvl_q;

  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        run;
  logic        wr_ctrl, wr_limit, wr_kick, wr_cause;
  logic        btn_evt, wdt_exp, enter_hold;

  reset_gen_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_rst),
    .level(btn_lvl)
  );

  // Event decode. Register writes are only honoured while running.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    wdata    = bswap32(d);
    run      = (state_q == ST_RUN);
    wr_ctrl  = 1'b0;
    wr_limit = 1'b0;
    wr_kick  = 1'b0;
    wr_cause = 1'b0;
    if (we && run) begin
      case (reg_addr_e'(a))
        REG_CTRL:  wr_ctrl  = 1'b1;
        REG_LIMIT: wr_limit = 1'b1;
        REG_KICK:  wr_kick  = 1'b1;
        REG_CAUSE: wr_cause = 1'b1;
        default:   ;
      endcase
    end
    btn_evt    = run && btn_lvl && !btn_lvl_q;
    // A CTRL or KICK write landing in the expiry cycle restarts the count
    // instead of letting the watchdog fire.
    wdt_exp    = run && wdt_en_q && (wdt_cnt_q == limit_q) && !(wr_ctrl || wr_kick);
    enter_hold = btn_evt || wdt_exp;
    // Setting a cause bit wins over a coincident clearing write.
    cause_d    = wr_cause ? '0 : cause_q;
    if (btn_evt) cause_d[CAUSE_BTN] = 1'b1;
    if (wdt_exp) cause_d[CAUSE_WDT] = 1'b1;
  end

  // Sequencer next state.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (enter_hold) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // rst_globl comes straight from its own flop so it cannot glitch; it is
  // loaded from state_d so it changes on the same edge the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      rst_globl  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_globl  <= (state_d == ST_HOLD);
    end
  end

  // Watchdog and MMIO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_en_q  <= 1'b0;
      wdt_cnt_q <= '0;
      limit_q   <= '1;
      cause_q   <= CAUSE_W'(1) << CAUSE_POR;
      btn_lvl_q <= 1'b0;
    end else begin
      btn_lvl_q <= btn_lvl;
      cause_q   <= cause_d;
      if (wr_limit) limit_q <= wdata[WDT_BITS-1:0];
      if (enter_hold) begin
        wdt_en_q  <= 1'b0;
        wdt_cnt_q <= '0;
      end else begin
        if (wr_ctrl) wdt_en_q <= wdata[0];
        if (wr_ctrl || wr_kick) begin
          wdt_cnt_q <= '0;
        end else if (run && wdt_en_q) begin
          wdt_cnt_q <= wdt_cnt_q + WDT_BITS'(1);
        end
      end
    end
  end

  // Read mux.
  always_comb begin
    rdata = '0;
    case (reg_addr_e'(a))
      REG_CTRL:  rdata[0]              = wdt_en_q;
      REG_LIMIT: rdata[WDT_BITS-1:0]   = limit_q;
      REG_KICK:  rdata                 = '0;
      REG_CAUSE: rdata[CAUSE_W-1:0]    = cause_q;
      default:   rdata                 = '0;
    endcase
    spo = bswap32(rdata);
  end

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen with HOLD_CYCLES=4, DEBOUNCE_BITS=3.
// Stimulus pushes expected rst_globl transitions (level + clock edge number)
// and expected read data into queues; a monitor sampling on the falling edge
// pops and compares whenever rst_globl changes or a read is presented.
module tb_reset_gen;

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_LIMIT = 2'd1;
  localparam logic [1:0] A_KICK  = 2'd2;
  localparam logic [1:0] A_CAUSE = 2'd3;

  typedef struct {
    logic  level;
    int    stamp;
    string name;
  } edge_t;

  typedef struct {
    logic [31:0] value;
    string       name;
  } rd_t;

  logic        clk;
  logic        rst;
  logic        btn_rst;
  logic [1:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        rst_globl;

  logic        rd_req;
  int          cyc_n;
  int          n_checks;
  int          n_fail;
  int          c;
  edge_t       edge_q[$];
  rd_t         rd_q[$];

  reset_gen #(
    .HOLD_CYCLES  (4),
    .DEBOUNCE_BITS(3),
    .WDT_BITS     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_rst  (btn_rst),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo),
    .rst_globl(rst_globl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_edge(input logic level, input int stamp, input string name);
    edge_t e;
    e.level = level;
    e.stamp = stamp;
    e.name  = name;
    edge_q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    a  = addr;
    d  = bsw(data);
    we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] bus_exp, input string name);
    rd_t r;
    r.value = bus_exp;
    r.name  = name;
    rd_q.push_back(r);
    a      = addr;
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
  endtask

  // Monitor: compares every rst_globl transition and every presented read.
  initial begin
    logic  prev;
    edge_t e;
    rd_t   r;
    @(negedge clk);
    prev = rst_globl;
    forever begin
      @(negedge clk);
      if (rd_req && rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check(r.name, spo, r.value);
      end
      if (rst_globl !== prev) begin
        if (edge_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_edge: rst_globl became %b at edge %0d, none expected",
                   rst_globl, cyc_n);
        end else begin
          e = edge_q.pop_front();
          check({e.name, "_lvl"}, 32'(rst_globl), 32'(e.level));
          check({e.name, "_edge"}, cyc_n, e.stamp);
        end
        prev = rst_globl;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    btn_rst  = 1'b0;
    we       = 1'b0;
    a        = '0;
    d        = '0;
    rd_req   = 1'b0;

    // 1. Power-on reset: async assert, release 4 edges after rst drops.
    #2 rst = 1'b1;
    #1 check("por_async", 32'(rst_globl), 32'd1);
    step(3);
    exp_edge(1'b0, cyc_n + 4, "por_release");
    rst = 1'b0;
    wr(A_LIMIT, 32'd7);                    // lands in HOLD: must be dropped
    step(4);
    rd(A_CAUSE, 32'h0100_0000, "cause_por");
    rd(A_LIMIT, 32'hffff_ffff, "limit_reset");
    rd(A_CTRL, 32'h0, "ctrl_reset");

    // 2a. A 7-cycle button pulse is one short of the debounce window.
    btn_rst = 1'b1;
    step(7);
    btn_rst = 1'b0;
    step(6);

    // 2b. Bounce, then hold: one pulse 11 edges after the final rise.
    btn_rst = 1'b1; step(1);
    btn_rst = 1'b0; step(1);
    btn_rst = 1'b1; step(1);
    btn_rst = 1'b0; step(1);
    btn_rst = 1'b1;
    exp_edge(1'b1, cyc_n + 11, "btn_rise");
    exp_edge(1'b0, cyc_n + 15, "btn_fall");
    step(20);
    rd(A_CAUSE, bsw(32'h3), "cause_btn");
    step(30);                              // still held: no second reset
    btn_rst = 1'b0;
    step(15);                              // release is ignored

    // 3. Watchdog expiry 6 edges after the CTRL write.
    wr(A_LIMIT, 32'd5);
    wr(A_CTRL, 32'd1);
    exp_edge(1'b1, cyc_n + 6, "wdt_rise");
    exp_edge(1'b0, cyc_n + 10, "wdt_fall");
    step(12);
    rd(A_CTRL, 32'h0, "ctrl_after_wdt");
    rd(A_LIMIT, bsw(32'd5), "limit_5");
    rd(A_CAUSE, bsw(32'h7), "cause_all");
    wr(A_CAUSE, 32'h5a);
    rd(A_CAUSE, 32'h0, "cause_cleared");

    // 4. Regular kicks keep the watchdog quiet; a kick exactly at
    //    wdt_cnt==LIMIT also wins.
    wr(A_CTRL, 32'd1);
    rd(A_CTRL, bsw(32'd1), "ctrl_enabled");
    for (int i = 0; i < 25; i++) begin
      step(3);
      wr(A_KICK, 32'(i));
    end
    wr(A_CTRL, 32'd1);
    step(5);
    wr(A_KICK, 32'd0);                     // sampled on edge 6: count == 5
    step(2);
    wr(A_CTRL, 32'd0);
    rd(A_KICK, 32'h0, "kick_reads_0");

    // 5. Button press and watchdog expiry on the same edge.
    wr(A_CAUSE, 32'd0);
    btn_rst = 1'b1;
    c = cyc_n;
    exp_edge(1'b1, c + 11, "both_rise");
    exp_edge(1'b0, c + 15, "both_fall");
    step(4);
    wr(A_CTRL, 32'd1);                     // expiry lands on c+11
    step(14);
    rd(A_CAUSE, bsw(32'h6), "cause_btn_wdt");
    rd(A_CTRL, 32'h0, "ctrl_after_both");
    btn_rst = 1'b0;
    step(15);

    // 6a. LIMIT=0 expires on the first edge after enable; rst at hold_cnt==2.
    wr(A_LIMIT, 32'd0);
    wr(A_CTRL, 32'd1);
    exp_edge(1'b1, cyc_n + 1, "lim0_rise");
    step(3);
    rst = 1'b1;
    step(2);
    exp_edge(1'b0, cyc_n + 4, "hold_restart");
    rst = 1'b0;
    step(6);
    rd(A_CAUSE, bsw(32'h1), "cause_after_rst_hold");
    rd(A_LIMIT, 32'hffff_ffff, "limit_after_rst_hold");

    // 6b. rst during RUN with the watchdog enabled.
    wr(A_CTRL, 32'd1);
    step(3);
    exp_edge(1'b1, cyc_n, "run_async_rise");
    rst = 1'b1;
    #1 check("run_async_level", 32'(rst_globl), 32'd1);
    step(1);
    exp_edge(1'b0, cyc_n + 4, "run_restart");
    rst = 1'b0;
    step(6);
    rd(A_CTRL, 32'h0, "ctrl_after_rst_run");
    rd(A_CAUSE, bsw(32'h1), "cause_after_rst_run");

    step(5);
    check("edges_drained", 32'(edge_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
